// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte sources.
// Optional per-requester lock (reqLast) enabled by defining UART_ARB_LOCK_EN.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned ACK_TIMEOUT = 1024
) (
  input  logic                          clk,
  input  logic                          resetN,
  input  logic [NUM_REQ-1:0]            reqValid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] reqData,
`ifdef UART_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]            reqLast,
`endif
  output logic [NUM_REQ-1:0]            reqReady,
  output logic [DATA_WIDTH-1:0]         txData,
  output logic                          txStart,
  input  logic                          txBusy,
  output logic [$clog2(NUM_REQ)-1:0]    grantId,
  output logic                          errTimeout
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);
  localparam int unsigned CntW = $clog2(ACK_TIMEOUT);
  localparam logic [CntW-1:0] CntMax = CntW'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StStart, StWaitBusy, StWaitIdle} state_e;

  state_e                state_q, state_d;
  logic [IdxW-1:0]       ptr_q, ptr_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [IdxW-1:0]       gid_q, gid_d;
  logic                  lock_q, lock_d;

  logic                  win_found;
  logic [IdxW-1:0]       win_idx;
  logic [NUM_REQ-1:0]    ready_c;

  function automatic logic [IdxW-1:0] inc_wrap(input logic [IdxW-1:0] v);
    return (32'(v) == NUM_REQ - 1) ? '0 : v + IdxW'(1);
  endfunction

  // First valid requester at or after the pointer, wrapping around.
  always_comb begin
    int unsigned     cand;
    logic [IdxW-1:0] cidx;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cidx      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = (32'(ptr_q) + k) % NUM_REQ;
      cidx = IdxW'(cand);
      if (!win_found && reqValid[cidx]) begin
        win_found = 1'b1;
        win_idx   = cidx;
      end
    end
    if (lock_q) begin
      win_found = reqValid[gid_q];
      win_idx   = gid_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    data_d     = data_q;
    gid_d      = gid_q;
    lock_d     = lock_q;
    ready_c    = '0;
    txStart    = 1'b0;
    errTimeout = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          ready_c[win_idx] = 1'b1;
          data_d           = reqData[32'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
          gid_d            = win_idx;
          state_d          = StStart;
`ifdef UART_ARB_LOCK_EN
          // The pointer only moves once a locked burst is released.
          if (reqLast[win_idx]) begin
            lock_d = 1'b0;
            ptr_d  = inc_wrap(win_idx);
          end else begin
            lock_d = 1'b1;
          end
`else
          ptr_d = inc_wrap(win_idx);
`endif
        end
      end
      StStart: begin
        txStart = 1'b1;
        cnt_d   = '0;
        state_d = StWaitBusy;
      end
      StWaitBusy: begin
        if (txBusy) begin
          state_d = StWaitIdle;
        end else if (cnt_q == CntMax) begin
          errTimeout = 1'b1;
          state_d    = StIdle;
          if (lock_q) begin
            lock_d = 1'b0;
            ptr_d  = inc_wrap(gid_q);
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StWaitIdle: begin
        if (!txBusy) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Masked during reset so no strobe is shown for a transfer that cannot happen.
  assign reqReady = ready_c & {NUM_REQ{resetN}};
  assign txData   = data_q;
  assign grantId  = gid_q;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      gid_q   <= '0;
      lock_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      gid_q   <= gid_d;
      lock_q  <= lock_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: random requesters and a transmitter model.
module tb_uart_tx_arbiter;

  localparam int unsigned NumReq    = 4;
  localparam int unsigned Dw        = 8;
  localparam int unsigned AckTo     = 16;
  localparam int          MaxScript = 32;

  logic                 clk = 1'b0;
  logic                 resetN;
  logic [NumReq-1:0]    reqValid;
  logic [NumReq*Dw-1:0] reqData;
  logic [NumReq-1:0]    reqReady;
  logic [Dw-1:0]        txData;
  logic                 txStart;
  logic                 txBusy;
  logic [1:0]           grantId;
  logic                 errTimeout;
`ifdef UART_ARB_LOCK_EN
  logic [NumReq-1:0]    reqLast;
`endif

  uart_tx_arbiter #(
    .NUM_REQ    (NumReq),
    .DATA_WIDTH (Dw),
    .ACK_TIMEOUT(AckTo)
  ) dut (
    .clk       (clk),
    .resetN    (resetN),
    .reqValid  (reqValid),
    .reqData   (reqData),
`ifdef UART_ARB_LOCK_EN
    .reqLast   (reqLast),
`endif
    .reqReady  (reqReady),
    .txData    (txData),
    .txStart   (txStart),
    .txBusy    (txBusy),
    .grantId   (grantId),
    .errTimeout(errTimeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Stimulus state (written by the main process only)
  logic [Dw-1:0]     script_mem [NumReq][MaxScript];
  int                script_len [NumReq];
  int                script_pos [NumReq];
  int                taken      [NumReq];
  logic [NumReq-1:0] val;
  logic [Dw-1:0]     cur [NumReq];
  bit                rand_gap = 1'b0;
  bit                rand_to  = 1'b0;
  int                noack_req = 0;

  // Monitor / reference-model state (written by the monitor only)
  int            ack_cnt [NumReq];
  int            model_ptr = 0;
  bit            model_idle = 1'b1;
  bit            prev_rr = 1'b0;
  bit            prev_busy = 1'b0;
  bit            hold = 1'b0;
  logic [Dw-1:0] hold_byte;
  int            exp_id_q[$];
  logic [Dw-1:0] exp_dat_q[$];
  int            grant_log[$];
  int            to_seen = 0;
  int            to_cnt = 0;

  // Transmitter-model state (written by the transmitter model only)
  int noack_used = 0;
  int to_due = 0;

  assign reqValid = val;
  always_comb begin
    for (int i = 0; i < NumReq; i++) reqData[i*Dw +: Dw] = cur[i];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model and scoreboard, sampled on the falling edge.
  initial begin
    int w;
    int j;
    for (int i = 0; i < NumReq; i++) ack_cnt[i] = 0;
    forever begin
      @(negedge clk);
      if (!resetN) begin
        model_ptr  = 0;
        model_idle = 1'b1;
        prev_rr    = 1'b0;
        prev_busy  = 1'b0;
        hold       = 1'b0;
        to_seen    = to_due;
        exp_id_q.delete();
        exp_dat_q.delete();
      end else begin
        if (reqReady != '0) begin
          w = -1;
          for (int k = 0; k < NumReq; k++) begin
            j = (model_ptr + k) % NumReq;
            if (w < 0 && val[j]) w = j;
          end
          check("grant_onehot", 32'(reqReady), (w < 0) ? 32'd0 : (32'd1 << w));
          check("accept_only_when_idle", 32'(model_idle), 32'd1);
          for (int i = 0; i < NumReq; i++) if (reqReady[i]) ack_cnt[i]++;
          if (w >= 0) begin
            exp_id_q.push_back(w);
            exp_dat_q.push_back(cur[w]);
            grant_log.push_back(w);
            model_ptr = (w + 1) % NumReq;
          end
          model_idle = 1'b0;
        end
        if (txStart) begin
          check("start_follows_ready", 32'(prev_rr), 32'd1);
          check("start_pending", 32'(exp_id_q.size() > 0), 32'd1);
          if (exp_id_q.size() > 0) begin
            check("grant_id", 32'(grantId), 32'(exp_id_q.pop_front()));
            check("tx_data", 32'(txData), 32'(exp_dat_q.pop_front()));
          end
          hold      = 1'b1;
          hold_byte = txData;
        end else if (hold) begin
          check("tx_data_stable", 32'(txData), 32'(hold_byte));
        end
        if (prev_busy && !txBusy) begin
          model_idle = 1'b1;
          hold       = 1'b0;
        end
        if (errTimeout) begin
          check("timeout_expected", 32'(to_due != to_seen), 32'd1);
          check("timeout_cycle", 32'(cyc), 32'(to_due));
          to_seen    = to_due;
          to_cnt++;
          model_idle = 1'b1;
          hold       = 1'b0;
        end else if (to_due != to_seen && cyc > to_due) begin
          check("timeout_missing", 32'(errTimeout), 32'd1);
          to_seen = to_due;
        end
        prev_rr   = (reqReady != '0);
        prev_busy = txBusy;
      end
    end
  end

  // Transmitter model: acknowledges each start after 0..3 cycles, or never.
  initial begin
    int d;
    int l;
    txBusy = 1'b0;
    forever begin
      @(negedge clk);
      if (resetN && txStart) begin
        if (noack_used < noack_req || (rand_to && $urandom_range(0, 5) == 0)) begin
          if (noack_used < noack_req) noack_used++;
          to_due = cyc + AckTo;
        end else begin
          d = $urandom_range(0, 3);
          l = $urandom_range(2, 5);
          if (d > 0) begin
            repeat (d) @(posedge clk);
            #1;
          end
          txBusy = 1'b1;
          repeat (l) @(posedge clk);
          #1;
          txBusy = 1'b0;
        end
      end
    end
  end

  task automatic load(input int r, input logic [Dw-1:0] b);
    script_mem[r][script_len[r]] = b;
    script_len[r]++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < NumReq; i++) begin
      if (val[i] && ack_cnt[i] != taken[i]) begin
        val[i]   = 1'b0;
        taken[i] = ack_cnt[i];
      end
      if (!val[i] && script_pos[i] < script_len[i] && (!rand_gap || $urandom_range(0, 2) == 0))
      begin
        cur[i] = script_mem[i][script_pos[i]];
        script_pos[i]++;
        val[i] = 1'b1;
      end
    end
  endtask

  function automatic bit pending();
    bit b = (val != '0) || !model_idle || txBusy;
    for (int i = 0; i < NumReq; i++) if (script_pos[i] < script_len[i]) b = 1'b1;
    return b;
  endfunction

  task automatic drain(input string name);
    int n = 0;
    while (pending() && n < 5000) begin
      step();
      n++;
    end
    check({name, "_drained"}, 32'(n < 5000), 32'd1);
    repeat (3) step();
  endtask

  task automatic check_order(input string name, input int base, input int exp_ids[$]);
    check({name, "_count"}, 32'(grant_log.size() - base), 32'(exp_ids.size()));
    for (int k = 0; k < exp_ids.size() && base + k < grant_log.size(); k++)
      check(name, 32'(grant_log[base + k]), 32'(exp_ids[k]));
  endtask

  initial begin
    int base;
    int to_base;
    int n;
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int to_base;
    int n;
    resetN = 1'b0;
    for (int i = 0; i < NumReq; i++) begin
      cur[i] = 8'hEE;
      script_len[i] = 0;
      script_pos[i] = 0;
      taken[i] = 0;
    end
`ifdef UART_ARB_LOCK_EN
    reqLast = '1;
`endif
    val = '1;
    repeat (4) begin
      @(negedge clk);
      check("rst_req_ready", 32'(reqReady), 32'd0);
      check("rst_tx_start", 32'(txStart), 32'd0);
      check("rst_tx_data", 32'(txData), 32'd0);
      check("rst_grant_id", 32'(grantId), 32'd0);
      check("rst_err_timeout", 32'(errTimeout), 32'd0);
    end
    val = '0;
    @(posedge clk);
    #2 resetN = 1'b1;

    // Full contention from pointer 0
    base = grant_log.size();
    load(0, 8'h10); load(0, 8'h10); load(1, 8'h11); load(2, 8'h12); load(3, 8'h13);
    drain("contention");
    check_order("contention_order", base, '{0, 1, 2, 3, 0});

    // Move the pointer to 3, then 0 and 2 compete: wrap then skip
    load(2, 8'h22);
    drain("single");
    base = grant_log.size();
    load(0, 8'h30); load(2, 8'h32);
    drain("wrap");
    check_order("wrap_order", base, '{0, 2});

    // Unacknowledged start from requester 3, then requester 1 is served
    base    = grant_log.size();
    to_base = to_cnt;
    noack_req = noack_used + 1;
    load(3, 8'h77); load(1, 8'h44);
    drain("timeout");
    check("timeout_count", 32'(to_cnt - to_base), 32'd1);
    check_order("timeout_order", base, '{3, 1});

    // Random traffic with random gaps, latencies and occasional timeouts
    rand_gap = 1'b1;
    rand_to  = 1'b1;
    for (int i = 0; i < NumReq; i++)
      for (int k = 0; k < 10; k++) load(i, 8'($urandom));
    drain("random");
    rand_gap = 1'b0;
    rand_to  = 1'b0;

    // Reset while the transmitter is busy
    load(1, 8'h5A);
    n = 0;
    while (txBusy !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    check("reset_wait_busy", 32'(txBusy), 32'd1);
    step();
    #2 resetN = 1'b0;
    #1;
    check("midrst_tx_start", 32'(txStart), 32'd0);
    check("midrst_tx_data", 32'(txData), 32'd0);
    check("midrst_grant_id", 32'(grantId), 32'd0);
    check("midrst_req_ready", 32'(reqReady), 32'd0);
    repeat (7) begin
      step();
      check("midrst_hold_start", 32'(txStart), 32'd0);
    end
    @(posedge clk);
    #2 resetN = 1'b1;
    repeat (20) step();

    // Pointer restarts at 0 after reset
    base = grant_log.size();
    load(3, 8'h99); load(0, 8'h88);
    drain("post_reset");
    check_order("post_reset_order", base, '{0, 3});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter between NUM_REQ byte sources, using round-robin arbitration.
- Sits between client logic and the transmitter, which is clocked by the baud-rate generator's txClk domain output, synchronised into clk upstream.
- Sequences each byte: accept from a requester, pulse start, wait for transmitter busy, wait for transmitter idle.
- Flags a transmitter that never acknowledges a start.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 8, byte width.
- ACK_TIMEOUT, 1024, clk cycles allowed between txStart and txBusy rising (>=2).

Ports:
- clk  input  1  board clock.
- resetN  input  1  asynchronous active-low reset.
- reqValid  input  NUM_REQ  per-requester byte valid.
- reqData  input  NUM_REQ*DATA_WIDTH  requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- reqReady  output  NUM_REQ  one-hot accept strobe.
- txData  output  DATA_WIDTH  byte to transmitter, stable from txStart until txBusy falls.
- txStart  output  1  one-cycle start pulse.
- txBusy  input  1  transmitter busy, already synchronised to clk.
- grantId  output  $clog2(NUM_REQ)  index of the last accepted requester.
- errTimeout  output  1  one-cycle pulse on acknowledge timeout.

Behaviour:
- Reset (async, resetN=0):
  - state=IDLE.
  - reqReady=0, txStart=0, txData=0, grantId=0, errTimeout=0.
  - Priority pointer=0, timeout counter=0.
  - Asserting reset mid-transfer drops txStart immediately and discards the latched byte.
- FSM states: IDLE, START, WAIT_BUSY, WAIT_IDLE.
- IDLE:
  - Winner = first i with reqValid[i]=1, searching from the pointer upward with wrap (pointer, pointer+1, ..., NUM_REQ-1, 0, ...).
  - reqReady[winner]=1 combinationally in IDLE only; all other bits are 0.
  - Transfer occurs that cycle: txData<=reqData[winner], grantId<=winner, pointer<=(winner+1) mod NUM_REQ, next state START.
  - No reqValid: stay in IDLE with reqReady=0.
- START: txStart=1 for exactly this cycle; counter<=0; next state WAIT_BUSY.
- WAIT_BUSY:
  - txBusy=1: go to WAIT_IDLE.
  - Otherwise increment counter.
  - counter==ACK_TIMEOUT-1 with txBusy=0: errTimeout=1 for one cycle, byte dropped, go to IDLE.
- WAIT_IDLE: txBusy=0 returns to IDLE. Next acceptance is earliest the following cycle, so minimum spacing between reqReady strobes is 4 cycles.
- Requester rule: reqValid, once asserted, holds with stable data until reqReady. The arbiter tolerates a violating withdrawal, since it only samples in the transfer cycle.
- Simultaneous events:
  - All requesters valid: grants are 0,1,2,3,0,...
  - A requester rising while the arbiter is busy waits; no preemption.
  - txBusy already high in START: WAIT_BUSY exits next cycle.
- Pointer wrap: winner NUM_REQ-1 sets pointer=0.
- Sole requester: served back-to-back every 4+ cycles regardless of pointer.

Optional Feature:
- Macro: UART_ARB_LOCK_EN.
- With the macro defined:
  - Extra input reqLast (NUM_REQ bits), sampled in the transfer cycle.
  - Accepting a byte with reqLast=0 locks arbitration to that requester. IDLE then grants only that requester and ignores others, even if the locked requester is idle.
  - Accepting a byte with reqLast=1 releases the lock. The pointer advances only on release.
  - A timeout also releases the lock.
  - Reset clears the lock.
- Without the macro: no reqLast port; per-byte round robin as above.

Test Plan:
- Reset: hold resetN=0, drive reqValid=4'b1111 -> reqReady=0, txStart=0, txData=0 throughout. Pulse resetN low during WAIT_IDLE -> outputs clear the same cycle, no further txStart.
- Single requester: reqValid[2]=1, data 0xA5; model asserts txBusy 3 cycles after txStart for 10 cycles -> reqReady=4'b0100 once, txStart one cycle later, txData=0xA5, grantId=2, next accept after txBusy falls.
- Full contention: reqValid=4'b1111, bytes 0x10..0x13 -> grant order 0,1,2,3,0 with txData 0x10,0x11,0x12,0x13,0x10. Exactly one txStart per byte.
- Wrap/skip: pointer at 3, reqValid=4'b0101 -> grant 0 then 2.
- Timeout: ACK_TIMEOUT=16, txBusy held 0 -> errTimeout pulses 16 cycles after txStart, state returns IDLE, next requester served.
- Lock (UART_ARB_LOCK_EN): requester 1 sends 3 bytes with reqLast=0,0,1 while requester 0 is valid -> bytes 1,1,1 then 0. Without the macro -> interleaved 0,1,0,1.
